pitch_stabilizer: RTL and testbench

Consumes the raw FFT peak-bin stream from fft_pitch_detect, in the fft_clk domain. Debounces it into a committed pitch: a new bin is accepted only after STABLE_COUNT consecutive agreeing frames, and is released after STABLE_COUNT consecutive silent frames. Converts the committed bin to integer Hz through a 2-stage pipeline. Feeds the downstream note/display logic with a clean, glitch-free pitch.

---
 rtl/pitch_stabilizer.sv | 175 +++++++++++++++++
 tb/tb_pitch_stabilizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_stabilizer.sv
// Debounces the raw FFT peak-bin stream into a committed pitch and
// converts the committed bin to integer Hz through a 2-stage pipeline.
module pitch_stabilizer #(
    parameter int NSamples     = 1024,
    parameter int FS_HZ        = 48000,
    parameter int FW           = 16,
    parameter int STABLE_COUNT = 3,
    parameter int TOLERANCE    = 1,
    parameter int MIN_BIN      = 2,
    localparam int PW          = $clog2(NSamples)
) (
    input  logic          fft_clk,
    input  logic          reset,
    input  logic [PW-1:0] pitch_input_data,
    input  logic          pitch_input_valid,
    output logic [PW-1:0] pitch_bin_data,
    output logic [FW-1:0] pitch_hz_data,
    output logic          pitch_hz_valid,
    output logic          pitch_locked
);

    localparam int PRW = PW + $clog2(FS_HZ + 1);
    localparam int QW  = PRW - PW;
    localparam int CW  = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] SC = CW'(STABLE_COUNT);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  cand_q, cand_d;
    logic [CW-1:0]  match_q, match_d;
    logic [CW-1:0]  silent_q, silent_d;
    logic           held_q, held_d;

    logic           c_v_q, c_v_d;
    logic [PW-1:0]  c_bin_q, c_bin_d;
    logic           c_lk_q, c_lk_d;

    logic           p_v_q;
    logic [PW-1:0]  p_bin_q;
    logic           p_lk_q;
    logic [PRW-1:0] prod_q;

    logic [PW-1:0]  bin_q;
    logic [FW-1:0]  hz_q;
    logic           pulse_q;
    logic           lock_q;

    logic          silent;
    logic          match;
    logic          sil_hit;
    logic [PW-1:0] diff;
    logic [CW-1:0] match_inc;
    logic          lock_hit;
    logic [QW-1:0] hz_full;
    logic          hz_sat;
    logic [FW-1:0] hz_d;

    always_comb begin
        silent    = int'(pitch_input_data) < MIN_BIN;
        diff      = (pitch_input_data >= cand_q) ? pitch_input_data - cand_q
                                                 : cand_q - pitch_input_data;
        match     = !silent && (state_q != IDLE) && (int'(diff) <= TOLERANCE);
        match_inc = match_q + CW'(1);
        lock_hit  = match && (state_q == TRACK) && (match_inc == SC);
        // Release fires only on the step into saturation, not while held there.
        sil_hit   = pitch_input_valid && silent && held_q
                    && (silent_q == SC - CW'(1));
    end

    always_ff @(posedge fft_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            match_q  <= '0;
            silent_q <= '0;
            held_q   <= 1'b0;
            c_v_q    <= 1'b0;
            c_bin_q  <= '0;
            c_lk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            silent_q <= silent_d;
            held_q   <= held_d;
            c_v_q    <= c_v_d;
            c_bin_q  <= c_bin_d;
            c_lk_q   <= c_lk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        silent_d = silent_q;
        if (pitch_input_valid) begin
            if (silent) begin
                silent_d = (silent_q == SC) ? silent_q : silent_q + CW'(1);
                if (sil_hit || state_q == TRACK) begin
                    state_d = IDLE;
                    match_d = '0;
                end
            end else begin
                silent_d = '0;
                if (match) begin
                    if (state_q == TRACK) begin
                        match_d = match_inc;
                        if (lock_hit) state_d = LOCKED;
                    end
                end else begin
                    cand_d  = pitch_input_data;
                    match_d = CW'(1);
                    state_d = (STABLE_COUNT == 1) ? LOCKED : TRACK;
                end
            end
        end
    end

    always_comb begin
        c_v_d   = 1'b0;
        c_bin_d = '0;
        c_lk_d  = 1'b0;
        if (sil_hit) begin
            c_v_d = 1'b1;
        end else if (pitch_input_valid && lock_hit) begin
            c_v_d   = 1'b1;
            c_bin_d = cand_q;
            c_lk_d  = 1'b1;
        end else if (pitch_input_valid && !silent && !match
                     && STABLE_COUNT == 1) begin
            c_v_d   = 1'b1;
            c_bin_d = pitch_input_data;
            c_lk_d  = 1'b1;
        end
        held_d = c_v_d ? c_lk_d : held_q;
    end

    always_comb begin
        hz_full = prod_q[PRW-1:PW];
        hz_sat  = (QW > FW) ? |(hz_full >> FW) : 1'b0;
        hz_d    = hz_sat ? '1 : FW'(hz_full);
    end

    always_ff @(posedge fft_clk) begin
        if (reset) begin
            p_v_q   <= 1'b0;
            p_bin_q <= '0;
            p_lk_q  <= 1'b0;
            prod_q  <= '0;
            bin_q   <= '0;
            hz_q    <= '0;
            pulse_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            p_v_q   <= c_v_q;
            p_bin_q <= c_bin_q;
            p_lk_q  <= c_lk_q;
            prod_q  <= PRW'(c_bin_q) * PRW'(FS_HZ);
            pulse_q <= p_v_q;
            if (p_v_q) begin
                bin_q  <= p_bin_q;
                hz_q   <= hz_d;
                lock_q <= p_lk_q;
            end
        end
    end

    assign pitch_bin_data = bin_q;
    assign pitch_hz_data  = hz_q;
    assign pitch_hz_valid = pulse_q;
    assign pitch_locked   = lock_q;

endmodule

// File: tb/tb_pitch_stabilizer.sv
// Directed bench for pitch_stabilizer: sample-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_pitch_stabilizer;

    localparam int NS   = 1024;
    localparam int FS   = 48000;
    localparam int FW   = 16;
    localparam int SC   = 3;
    localparam int TOL  = 1;
    localparam int MINB = 2;
    localparam int PW   = $clog2(NS);

    logic          fft_clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] din = '0;
    logic          dv = 1'b0;
    logic [PW-1:0] pitch_bin_data;
    logic [FW-1:0] pitch_hz_data;
    logic          pitch_hz_valid;
    logic          pitch_locked;

    pitch_stabilizer #(
        .NSamples(NS), .FS_HZ(FS), .FW(FW),
        .STABLE_COUNT(SC), .TOLERANCE(TOL), .MIN_BIN(MINB)
    ) dut (
        .fft_clk(fft_clk),
        .reset(reset),
        .pitch_input_data(din),
        .pitch_input_valid(dv),
        .pitch_bin_data(pitch_bin_data),
        .pitch_hz_data(pitch_hz_data),
        .pitch_hz_valid(pitch_hz_valid),
        .pitch_locked(pitch_locked)
    );

    always #5 fft_clk = ~fft_clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    bit started = 1'b0;

    // Reference model state (sample-level description of the debouncer)
    int  phase;
    int  cand, cnt, sil, b;
    bit  held;
    bit  p0v, p1v, p0l, p1l;
    int  p0b, p1b;
    int  e_bin, e_hz;
    bit  e_v, e_lk;

    function automatic int hz_of(input int bin);
        longint h;
        h = (longint'(bin) * FS) / NS;
        if (h > 65535) h = 65535;
        return int'(h);
    endfunction

    task automatic commit(input int bin, input bit lk);
        p0v  = 1'b1;
        p0b  = bin;
        p0l  = lk;
        held = lk;
    endtask

    always @(posedge fft_clk) begin
        started = 1'b1;
        if (reset) begin
            e_bin = 0; e_hz = 0; e_v = 0; e_lk = 0;
            p0v = 0; p1v = 0; p0b = 0; p1b = 0; p0l = 0; p1l = 0;
            phase = 0; cand = 0; cnt = 0; sil = 0; held = 0;
        end else begin
            e_v = p1v;
            if (p1v) begin
                e_bin = p1b;
                e_hz  = hz_of(p1b);
                e_lk  = p1l;
            end
            p1v = p0v; p1b = p0b; p1l = p0l;
            p0v = 0;
            if (dv) begin
                b = int'(din);
                if (b < MINB) begin
                    if (sil < SC) begin
                        sil++;
                        if (sil == SC && held) begin
                            commit(0, 1'b0);
                            phase = 0;
                            cnt = 0;
                        end
                    end
                    if (phase == 1) begin
                        phase = 0;
                        cnt = 0;
                    end
                end else begin
                    sil = 0;
                    if (phase != 0 && b - cand <= TOL && cand - b <= TOL) begin
                        if (phase == 1) begin
                            cnt++;
                            if (cnt == SC) begin
                                commit(cand, 1'b1);
                                phase = 2;
                            end
                        end
                    end else begin
                        cand = b;
                        cnt = 1;
                        phase = 1;
                        if (cnt == SC) begin
                            commit(cand, 1'b1);
                            phase = 2;
                        end
                    end
                end
            end
        end
    end

    always @(negedge fft_clk) begin
        if (started) begin
            tests++;
            if (int'(pitch_bin_data) != e_bin || int'(pitch_hz_data) != e_hz
                || pitch_hz_valid != e_v || pitch_locked != e_lk) begin
                fails++;
                $display("FAIL cycle_model t=%0t got bin=%0d hz=%0d v=%0b lk=%0b want bin=%0d hz=%0d v=%0b lk=%0b",
                         $time, pitch_bin_data, pitch_hz_data, pitch_hz_valid,
                         pitch_locked, e_bin, e_hz, e_v, e_lk);
            end
            if (pitch_hz_valid) pulses++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic feed(input int bin);
        @(posedge fft_clk);
        #1;
        din = PW'(bin);
        dv  = 1'b1;
    endtask

    task automatic feed3(input int bin);
        for (int i = 0; i < 3; i++) feed(bin);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fft_clk);
            #1;
            dv = 1'b0;
        end
    endtask

    task automatic chk_out(input string nm, input int bin, input int hz,
                           input int lk, input int np);
        chk({nm, "_bin"}, int'(pitch_bin_data), bin);
        chk({nm, "_hz"}, int'(pitch_hz_data), hz);
        chk({nm, "_locked"}, int'(pitch_locked), lk);
        chk({nm, "_pulses"}, pulses, np);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge fft_clk);
            #1;
            din = PW'(20 + i);
            dv  = ~dv;
        end
        chk_out("reset", 0, 0, 0, 0);
        @(posedge fft_clk);
        #1;
        reset = 1'b0;
        dv = 1'b0;
        idle(2);

        feed3(20);
        idle(4);
        chk_out("lock20", 20, 937, 1, 1);
        feed(20); feed(20);
        idle(4);
        chk_out("hold20", 20, 937, 1, 1);

        feed(40); feed(40);
        idle(4);
        chk_out("relock_wait", 20, 937, 1, 1);
        feed(40);
        idle(4);
        chk_out("relock40", 40, 1875, 1, 2);

        feed3(1);
        idle(4);
        chk_out("release", 0, 0, 0, 3);

        feed3(40);
        idle(4);
        feed(1); feed(1); feed(40); feed(1); feed(1);
        idle(4);
        chk_out("no_release", 40, 1875, 1, 4);
        feed3(1);
        idle(4);
        chk_out("release2", 0, 0, 0, 5);

        feed(20); feed(21); feed(20);
        idle(4);
        chk_out("tol_lock", 20, 937, 1, 6);
        feed3(1);
        idle(4);
        feed(20); feed(22); feed(20);
        idle(4);
        chk_out("tol_miss", 0, 0, 0, 7);
        feed3(1);
        idle(4);
        chk_out("idle_silence", 0, 0, 0, 7);

        feed3(1023);
        idle(4);
        chk_out("max_bin", 1023, 47953, 1, 8);
        feed3(1);
        idle(4);

        feed(30); feed(30);
        @(posedge fft_clk);
        #1;
        dv = 1'b0;
        reset = 1'b1;
        @(posedge fft_clk);
        #1;
        reset = 1'b0;
        feed(30);
        idle(4);
        chk_out("mid_reset", 0, 0, 0, 9);
        feed(30); feed(30);
        idle(4);
        chk_out("lock30", 30, 1406, 1, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
